ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand selection for the MIPS pipeline.
//  Latches ID-stage operands, forwards results from EX/MEM and MEM/WB, and applies
//  immediate extension. It then presents ALU operand A, ALU operand B and store data.
//  Supersedes the fixed 32-bit ALUSrc operand mux: parametrised width, forwarding,
//  a 3-mode immediate extender, and stall/flush control.
// PARAMETERS
//  DATA_W      32  datapath width (>= IMM_W)
//  IMM_W       16  instruction immediate width
//  REG_ADDR_W  5   register-file address width
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           synchronous, active-high
//  stall         in   1           hold ID/EX register contents
//  flush         in   1           load a bubble into ID/EX
//  id_valid      in   1           ID stage holds a real instruction
//  id_read_rs    in   DATA_W      register-file rs data
//  id_read_rt    in   DATA_W      register-file rt data
//  id_imm        in   IMM_W       raw immediate
//  id_rs         in   REG_ADDR_W  rs address
//  id_rt         in   REG_ADDR_W  rt address
//  id_alu_src    in   1           1: B = extended imm, 0: B = forwarded rt
//  id_ext_mode   in   2           00 sign, 01 zero, 10 upper (imm<<(DATA_W-IMM_W)), 11 = 00
//  exmem_wr      in   1           EX/MEM writes a register
//  exmem_rd      in   REG_ADDR_W  EX/MEM destination
//  exmem_result  in   DATA_W      EX/MEM ALU result
//  memwb_wr      in   1           MEM/WB writes a register
//  memwb_rd      in   REG_ADDR_W  MEM/WB destination
//  memwb_result  in   DATA_W      MEM/WB write-back value
//  ex_valid      out  1           EX stage holds a real instruction
//  ex_op_a       out  DATA_W      ALU operand A
//  ex_op_b       out  DATA_W      ALU operand B
//  ex_store_data out  DATA_W      forwarded rt, used for SW
//  ex_fwd_a      out  2           A source: 00 reg, 01 MEM/WB, 10 EX/MEM
//  ex_fwd_b      out  2           rt source: same encoding
// BEHAVIOUR
//  - ID/EX register: all id_* fields. Update priority per rising clk:
//    reset > flush > stall > load.
//  - reset: every ID/EX field is cleared to 0, including valid. Outputs are then
//    ex_valid=0, op_a=op_b=store_data=0 and fwd_a=fwd_b=00.
//  - flush: clears valid and all fields to 0, including the rs/rt addresses, so no
//    forwarding is possible. flush together with stall is still a flush.
//  - stall (no flush): the register holds its contents. Outputs still follow the
//    live exmem_*/memwb_* inputs combinationally.
//  - load: register <= id_* on each clk edge. Latency ID->EX register is 1 cycle.
//  - Forwarding is combinational from the register and the live forward inputs; it
//    adds 0 cycles of latency.
//    For src in {rs,rt}:
//      if exmem_wr && exmem_rd==src && src!=0 -> exmem_result (10)
//      elif memwb_wr && memwb_rd==src && src!=0 -> memwb_result (01)
//      else latched register value (00)
//    EX/MEM has priority over MEM/WB when both match. Register 0 is never forwarded.
//  - ex_op_a = forwarded rs. ex_store_data = forwarded rt, independent of alu_src.
//  - ex_op_b = alu_src ? ext_imm : forwarded rt. ex_fwd_b still reports the rt
//    source when alu_src=1.
//  - ext_imm:
//      sign:  {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
//      zero:  {0, imm}
//      upper: {imm, {(DATA_W-IMM_W){0}}}
//    If DATA_W==IMM_W, all three modes yield imm.
//  - Forwarding is qualified only by the *_wr inputs, not by ex_valid.
//  - No internal hazard detection. The load-use stall and bubble are generated
//    externally via stall and flush.
// TESTING
//  1 reset held 2 cycles with id_* nonzero -> ex_valid=0, op_a=op_b=store_data=0,
//    fwd_a=fwd_b=00.
//  2 load rs=3 (0x11), rt=4 (0x22), alu_src=0, no writers -> next cycle op_a=0x11,
//    op_b=0x22, fwd=00/00.
//  3 latched rs=rt=5, exmem_wr=1 rd=5 result=0xAAAA and memwb_wr=1 rd=5
//    result=0xBBBB -> op_a=op_b=0xAAAA, fwd_a=fwd_b=10. Then drop exmem_wr ->
//    op_a=op_b=0xBBBB, fwd=01.
//  4 rs=0 with exmem_wr=1 rd=0 result=0xFFFF_FFFF, reg data 0 -> op_a=0, fwd_a=00.
//  5 imm=0x8001, alu_src=1, rt fwd from EX/MEM=0x1234:
//      mode 00 -> op_b=0xFFFF8001
//      mode 01 -> op_b=0x00008001
//      mode 10 -> op_b=0x80010000
//    In all three modes store_data=0x1234 and fwd_b=10.
//  6 stall 3 cycles while id_* changes -> register held, outputs unchanged.
//    Then stall+flush together -> ex_valid=0, op_a=0.
//    Then release both -> the new id_* value appears 1 cycle later.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// ----------------------------------------------------------------------------
// ex_operand_stage_if
//  Bundles the ID/EX operand-stage signals: pipeline control (stall/flush),
//  the ID-stage instruction fields, the EX/MEM and MEM/WB forwarding sources,
//  and the EX-stage operand outputs.
//  Modports:
//    master : surrounding pipeline; drives the stall/flush, id_*, exmem_* and
//             memwb_* signals and receives ex_*.
//    slave  : ex_operand_stage; receives the control, id_* and forwarding
//             signals and drives ex_*.
// ----------------------------------------------------------------------------
interface ex_operand_stage_if #(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int REG_ADDR_W = 5
);
  // Pipeline control
  logic                  stall;
  logic                  flush;

  // ID-stage instruction fields
  logic                  id_valid;
  logic [DATA_W-1:0]     id_read_rs;
  logic [DATA_W-1:0]     id_read_rt;
  logic [IMM_W-1:0]      id_imm;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_alu_src;
  logic [1:0]            id_ext_mode;

  // Forwarding sources
  logic                  exmem_wr;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [DATA_W-1:0]     exmem_result;
  logic                  memwb_wr;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [DATA_W-1:0]     memwb_result;

  // EX-stage operands
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_op_a;
  logic [DATA_W-1:0]     ex_op_b;
  logic [DATA_W-1:0]     ex_store_data;
  logic [1:0]            ex_fwd_a;
  logic [1:0]            ex_fwd_b;

  modport master (
    output stall, flush,
    output id_valid, id_read_rs, id_read_rt, id_imm, id_rs, id_rt,
           id_alu_src, id_ext_mode,
    output exmem_wr, exmem_rd, exmem_result,
    output memwb_wr, memwb_rd, memwb_result,
    input  ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_read_rs, id_read_rt, id_imm, id_rs, id_rt,
           id_alu_src, id_ext_mode,
    input  exmem_wr, exmem_rd, exmem_result,
    input  memwb_wr, memwb_rd, memwb_result,
    output ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ----------------------------------------------------------------------------
// ex_operand_stage
//  ID/EX pipeline register followed by EX-stage operand selection: operand
//  forwarding from EX/MEM and MEM/WB, a three-mode immediate extender, and the
//  ALU operand B mux.
//  Ports:
//    clk   : rising-edge clock
//    reset : synchronous, active-high; clears the whole ID/EX register
//    bus   : ex_operand_stage_if.slave
//            in  : stall, flush, id_*, exmem_*, memwb_*
//            out : ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_fwd_a, ex_fwd_b
//  Register update priority per edge: reset > flush > stall > load.
//  Forwarding and extension are purely combinational from the register and
//  the live forwarding inputs.
// ----------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int REG_ADDR_W = 5
) (
  input logic              clk,
  input logic              reset,
  ex_operand_stage_if.slave bus
);

  // Forwarding source encoding reported on ex_fwd_a / ex_fwd_b
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     read_rs;
    logic [DATA_W-1:0]     read_rt;
    logic [IMM_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  alu_src;
    logic [1:0]            ext_mode;
  } idex_t;

  idex_t idex_q;
  idex_t idex_d;

  // --------------------------------------------------------------------------
  // ID/EX register. A flush zeroes the addresses too, so a bubble can never
  // match a forwarding destination; flush wins over stall.
  // --------------------------------------------------------------------------
  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d = '0;
    end else if (!bus.stall) begin
      idex_d.valid    = bus.id_valid;
      idex_d.read_rs  = bus.id_read_rs;
      idex_d.read_rt  = bus.id_read_rt;
      idex_d.imm      = bus.id_imm;
      idex_d.rs       = bus.id_rs;
      idex_d.rt       = bus.id_rt;
      idex_d.alu_src  = bus.id_alu_src;
      idex_d.ext_mode = bus.id_ext_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding: index 0 is rs (operand A), index 1 is rt (operand B / store).
  // EX/MEM is the younger result, so it beats MEM/WB. Register 0 is hardwired
  // to zero and is never forwarded, whatever a writer claims.
  // --------------------------------------------------------------------------
  logic [1:0][REG_ADDR_W-1:0] src_addr;
  logic [1:0][DATA_W-1:0]     src_data;
  logic [1:0][1:0]            fwd_sel;
  logic [1:0][DATA_W-1:0]     fwd_data;

  assign src_addr[0] = idex_q.rs;
  assign src_addr[1] = idex_q.rt;
  assign src_data[0] = idex_q.read_rs;
  assign src_data[1] = idex_q.read_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [1:0]        sel;
      logic [DATA_W-1:0] data;

      always_comb begin
        sel  = FWD_REG;
        data = src_data[gi];
        if (src_addr[gi] != '0) begin
          if (bus.exmem_wr && (bus.exmem_rd == src_addr[gi])) begin
            sel  = FWD_EXMEM;
            data = bus.exmem_result;
          end else if (bus.memwb_wr && (bus.memwb_rd == src_addr[gi])) begin
            sel  = FWD_MEMWB;
            data = bus.memwb_result;
          end
        end
      end

      assign fwd_sel[gi]  = sel;
      assign fwd_data[gi] = data;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Immediate extension. Mode 11 behaves as sign extension. With no spare
  // bits (DATA_W == IMM_W) every mode passes the immediate through unchanged.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] ext_imm;

  generate
    if (DATA_W == IMM_W) begin : g_ext_none
      assign ext_imm = idex_q.imm;
    end else begin : g_ext
      localparam int PAD_W = DATA_W - IMM_W;
      always_comb begin
        case (idex_q.ext_mode)
          2'b01:   ext_imm = {{PAD_W{1'b0}}, idex_q.imm};
          2'b10:   ext_imm = {idex_q.imm, {PAD_W{1'b0}}};
          default: ext_imm = {{PAD_W{idex_q.imm[IMM_W-1]}}, idex_q.imm};
        endcase
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs. Store data is always the forwarded rt, and ex_fwd_b reports the
  // rt source even when operand B is the immediate.
  // --------------------------------------------------------------------------
  assign bus.ex_valid      = idex_q.valid;
  assign bus.ex_op_a       = fwd_data[0];
  assign bus.ex_op_b       = idex_q.alu_src ? ext_imm : fwd_data[1];
  assign bus.ex_store_data = fwd_data[1];
  assign bus.ex_fwd_a      = fwd_sel[0];
  assign bus.ex_fwd_b      = fwd_sel[1];

endmodule
